axi_conv_engine: RTL and testbench
==================================

AXI_CONV_ENGINE -- requirements
Module: axi_conv_engine

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 10, the AXI4-Lite byte address width.
REQ-003 SHALL have parameter KSIZE, default 3, the kernel edge length (odd, 1..7).
REQ-004 SHALL have parameter WSIZE, default 4, the world edge length (KSIZE..8).
REQ-005 SHALL have port S_AXI_ACLK, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port S_AXI_ARESET, input, 1, the asynchronous, active-high reset.
REQ-007 SHALL have ports S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY and RDATA/RRESP/RVALID/RREADY, with standard AXI4-Lite slave directions and widths.
REQ-008 SHALL have port irq, output, 1, a level interrupt equal to STATUS.done AND CTRL.irq_en.

Function
REQ-009 Address map SHALL be: 0x000 CTRL (bit0 start, write-1 self-clearing; bit1 irq_en; bit2 done_clr, write-1); 0x004 STATUS (read-only: bit0 busy, bit1 done, bit2 err); 0x008 I; 0x00C J; 0x010 RESULT (read-only).
REQ-010 Kernel cell [r][c] SHALL be at 0x100+4*(r*KSIZE+c) and world cell [r][c] at 0x200+4*(r*WSIZE+c); all cells are 32-bit signed.
REQ-011 Unmapped addresses SHALL read 0 and ignore writes; BRESP and RRESP SHALL always be OKAY.
REQ-012 Writes SHALL honour WSTRB per byte.
REQ-013 The write channel SHALL assert AWREADY and WREADY together for exactly one cycle when AWVALID and WVALID are both high and BVALID is low; BVALID SHALL be set the next cycle and held until BREADY.
REQ-014 The read channel SHALL assert ARREADY for one cycle when ARVALID is high and RVALID is low; RDATA/RVALID SHALL be registered the next cycle and held until RREADY.
REQ-015 The FSM SHALL have states IDLE, MAC and FINISH.
REQ-016 IDLE SHALL move to MAC on a start write when I<WSIZE and J<WSIZE, latching I, J, clearing the accumulator and setting busy, clearing done and clearing err.
REQ-017 MAC SHALL perform one multiply-accumulate per cycle over r,c in raster order for KSIZE*KSIZE cycles, then go to FINISH.
REQ-018 Each term SHALL be kernel[r][c]*world[I+r-KSIZE/2][J+c-KSIZE/2], signed 32x32; the sum SHALL be truncated to 32 bits (two's-complement wrap).
REQ-019 FINISH SHALL write RESULT, clear busy, set done and return to IDLE; done SHALL be high exactly KSIZE*KSIZE+2 cycles after the start write is accepted.
REQ-020 A start with I>=WSIZE or J>=WSIZE SHALL set err and done the next cycle, leave RESULT unchanged and not enter MAC.
REQ-021 A start while busy SHALL be ignored; kernel, world, I and J writes while busy SHALL get OKAY and be discarded.
REQ-022 done SHALL be sticky until a done_clr write or the next accepted start; done_clr and start in the same write SHALL resolve to start.

Reset
REQ-023 Asserting S_AXI_ARESET SHALL immediately force all READY/VALID outputs, RDATA, irq, all registers, kernel, world, RESULT and accumulator to 0 and the FSM to IDLE, aborting any operation.

Configuration
REQ-024 With macro CONV_WRAP_EN defined, world indices SHALL wrap modulo WSIZE (toroidal); when undefined, out-of-range neighbours SHALL contribute 0 (zero padding).

Verification (KSIZE=3, WSIZE=4)
REQ-025 Release reset and read every mapped address -> all read 0, irq=0.
REQ-026 Kernel=1..9 in raster order, world all 1, I=J=1, start -> done 11 cycles after start acceptance, RESULT=45, irq=1 if irq_en is set.
REQ-027 Kernel all 1, world[r][c]=4r+c, I=J=0 -> RESULT=60 with CONV_WRAP_EN, RESULT=10 without.
REQ-028 Kernel centre=0xFFFFFFFE (others 0), world[1][1]=7, I=J=1 -> RESULT=0xFFFFFFF2.
REQ-029 Second start and a world write 3 cycles after the first start -> single result, world unchanged; then I=4 and start -> err=1, done=1, RESULT unchanged.
REQ-030 Assert reset during MAC -> busy=0, done=0, RESULT=0 immediately; a fresh run afterwards computes correctly.

Source files
------------

// File: rtl/axi_conv_engine_if.sv
// AXI4-Lite bus bundle for the convolution engine register file.
// The slave modport is used by the engine, the master modport by a host or bench.
interface axi_conv_engine_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_conv_engine.sv
// AXI4-Lite 2D convolution engine: one KSIZE x KSIZE kernel MAC per cycle around world cell (I,J).
// Define CONV_WRAP_EN for toroidal world indexing; otherwise out-of-range neighbours are zero.
module axi_conv_engine #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10,
  parameter int KSIZE = 3,
  parameter int WSIZE = 4
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  axi_conv_engine_if.slave    s_axi,
  output logic                irq
);
  localparam int KK   = KSIZE * KSIZE;
  localparam int WW   = WSIZE * WSIZE;
  localparam int HALF = KSIZE / 2;

  typedef enum logic [1:0] {IDLE, MAC, FINISH} state_t;
  state_t state_reg;

  logic        awready_reg, bvalid_reg, arready_reg, rvalid_reg;
  logic [31:0] rdata_reg;
  logic        irq_en_reg, start_reg, busy_reg, done_reg, err_reg;
  logic [31:0] i_reg, j_reg, result_reg, acc_reg;
  logic [2:0]  i_lat_reg, j_lat_reg, r_reg, c_reg;

  logic [KK-1:0][31:0] kernel_q;
  logic [WW-1:0][31:0] world_q;

  logic        wr_fire, rd_fire, wr_lock;
  logic [31:0] aw_word, ar_word, rd_mux;
  logic signed [31:0] row_s, col_s, w_idx;
  logic [31:0] k_idx, k_val, w_val, term;
  logic        in_range;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    merge = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) merge[8*b +: 8] = d[8*b +: 8];
  endfunction

  assign wr_fire = awready_reg & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_fire = arready_reg & s_axi.S_AXI_ARVALID;
  // Operands are frozen from the start write until the result is posted.
  assign wr_lock = start_reg | busy_reg;
  assign aw_word = 32'(s_axi.S_AXI_AWADDR) >> 2;
  assign ar_word = 32'(s_axi.S_AXI_ARADDR) >> 2;

  assign s_axi.S_AXI_AWREADY = awready_reg;
  assign s_axi.S_AXI_WREADY  = awready_reg;
  assign s_axi.S_AXI_BVALID  = bvalid_reg;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_reg;
  assign s_axi.S_AXI_RVALID  = rvalid_reg;
  assign s_axi.S_AXI_RDATA   = rdata_reg;
  assign s_axi.S_AXI_RRESP   = 2'b00;
  assign irq = done_reg & irq_en_reg;

  generate
    for (genvar gi = 0; gi < KK; gi++) begin : g_kernel
      logic [31:0] cell_reg;
      always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET)
          cell_reg <= '0;
        else if (wr_fire && !wr_lock && aw_word == 32'h40 + 32'(gi))
          cell_reg <= merge(cell_reg, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
      end
      assign kernel_q[gi] = cell_reg;
    end
    for (genvar gi = 0; gi < WW; gi++) begin : g_world
      logic [31:0] cell_reg;
      always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET)
          cell_reg <= '0;
        else if (wr_fire && !wr_lock && aw_word == 32'h80 + 32'(gi))
          cell_reg <= merge(cell_reg, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
      end
      assign world_q[gi] = cell_reg;
    end
  endgenerate

  always_comb begin
    rd_mux = '0;
    case (ar_word)
      32'h0: rd_mux = {29'd0, 1'b0, irq_en_reg, start_reg};
      32'h1: rd_mux = {29'd0, err_reg, done_reg, busy_reg};
      32'h2: rd_mux = i_reg;
      32'h3: rd_mux = j_reg;
      32'h4: rd_mux = result_reg;
      default: begin
        for (int n = 0; n < KK; n++)
          if (ar_word == 32'h40 + 32'(n)) rd_mux = kernel_q[n];
        for (int n = 0; n < WW; n++)
          if (ar_word == 32'h80 + 32'(n)) rd_mux = world_q[n];
      end
    endcase
  end

  // Neighbour of (I,J) for the current kernel tap, folded back or masked at the edges.
  always_comb begin
    row_s = $signed(32'(i_lat_reg)) + $signed(32'(r_reg)) - HALF;
    col_s = $signed(32'(j_lat_reg)) + $signed(32'(c_reg)) - HALF;
`ifdef CONV_WRAP_EN
    if (row_s < 0) row_s = row_s + WSIZE;
    else if (row_s >= WSIZE) row_s = row_s - WSIZE;
    if (col_s < 0) col_s = col_s + WSIZE;
    else if (col_s >= WSIZE) col_s = col_s - WSIZE;
    in_range = 1'b1;
`else
    in_range = (row_s >= 0) && (row_s < WSIZE) && (col_s >= 0) && (col_s < WSIZE);
`endif
    w_idx = row_s * WSIZE + col_s;
    k_idx = 32'(r_reg) * KSIZE + 32'(c_reg);
    w_val = '0;
    k_val = '0;
    if (in_range)
      for (int n = 0; n < WW; n++)
        if (w_idx == n) w_val = world_q[n];
    for (int n = 0; n < KK; n++)
      if (k_idx == 32'(n)) k_val = kernel_q[n];
    term = k_val * w_val;
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_reg   <= IDLE;
      awready_reg <= 1'b0;
      bvalid_reg  <= 1'b0;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      irq_en_reg  <= 1'b0;
      start_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      i_reg       <= '0;
      j_reg       <= '0;
      result_reg  <= '0;
      acc_reg     <= '0;
      i_lat_reg   <= '0;
      j_lat_reg   <= '0;
      r_reg       <= '0;
      c_reg       <= '0;
    end else begin
      awready_reg <= !awready_reg && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID && !bvalid_reg;
      if (bvalid_reg && s_axi.S_AXI_BREADY) bvalid_reg <= 1'b0;
      else if (wr_fire) bvalid_reg <= 1'b1;

      arready_reg <= !arready_reg && s_axi.S_AXI_ARVALID && !rvalid_reg;
      if (rd_fire) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_mux;
      end else if (rvalid_reg && s_axi.S_AXI_RREADY) begin
        rvalid_reg <= 1'b0;
      end

      start_reg <= 1'b0;
      if (wr_fire) begin
        case (aw_word)
          32'h0: if (s_axi.S_AXI_WSTRB[0]) begin
            irq_en_reg <= s_axi.S_AXI_WDATA[1];
            if (s_axi.S_AXI_WDATA[2]) done_reg <= 1'b0;
            if (s_axi.S_AXI_WDATA[0] && !wr_lock) start_reg <= 1'b1;
          end
          32'h2: if (!wr_lock) i_reg <= merge(i_reg, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
          32'h3: if (!wr_lock) j_reg <= merge(j_reg, s_axi.S_AXI_WDATA, s_axi.S_AXI_WSTRB);
          default: ;
        endcase
      end

      case (state_reg)
        IDLE: if (start_reg) begin
          if (i_reg < WSIZE && j_reg < WSIZE) begin
            i_lat_reg <= i_reg[2:0];
            j_lat_reg <= j_reg[2:0];
            acc_reg   <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            state_reg <= MAC;
          end else begin
            err_reg  <= 1'b1;
            done_reg <= 1'b1;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + term;
          if (c_reg == 3'(KSIZE - 1)) begin
            c_reg <= '0;
            r_reg <= r_reg + 3'd1;
            if (r_reg == 3'(KSIZE - 1)) state_reg <= FINISH;
          end else begin
            c_reg <= c_reg + 3'd1;
          end
        end
        FINISH: begin
          result_reg <= acc_reg;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_conv_engine.sv
// Directed and randomized bench for axi_conv_engine (KSIZE=3, WSIZE=4) against a plain-arithmetic convolution model.
module tb_axi_conv_engine;
  localparam int K = 3;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  axi_conv_engine_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(10)) bus ();

  axi_conv_engine #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(10), .KSIZE(K), .WSIZE(W)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int rise_cyc = 0;
  logic irq_d = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (irq === 1'b1 && irq_d !== 1'b1) rise_cyc <= cyc;
    irq_d <= irq;
  end

  int tests = 0;
  int fails = 0;
  int acc_cyc = 0;
  logic [31:0] m_k [K*K];
  logic [31:0] m_w [W*W];
  logic [31:0] m_res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected handshake", tag);
  endtask

  // Reference: direct sum over the kernel window, 32-bit wrapping arithmetic.
  function automatic logic [31:0] ref_conv(input int i, input int j);
    logic [31:0] s = 32'd0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) begin
        int y = i + r - K/2;
        int x = j + c - K/2;
`ifdef CONV_WRAP_EN
        y = (y + W) % W;
        x = (x + W) % W;
`else
        if (y < 0 || y >= W || x < 0 || x >= W) continue;
`endif
        s = s + m_k[r*K+c] * m_w[y*W+x];
      end
    return s;
  endfunction

  task automatic axi_write(input int addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clk);
    bus.S_AXI_AWADDR = 10'(addr);
    bus.S_AXI_WDATA = data;
    bus.S_AXI_WSTRB = strb;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID = 1'b1;
    n = 0;
    while (bus.S_AXI_AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      timeout("awready_wait");
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    n = 0;
    while (bus.S_AXI_BVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin timeout("bvalid_wait"); bus.S_AXI_BREADY = 1'b0; return; end
    check("bresp", 32'(bus.S_AXI_BRESP), 32'd0);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input int addr, output logic [31:0] data);
    int n;
    data = 32'hxxxxxxxx;
    @(negedge clk);
    bus.S_AXI_ARADDR = 10'(addr);
    bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (bus.S_AXI_ARREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin timeout("arready_wait"); bus.S_AXI_ARVALID = 1'b0; return; end
    @(posedge clk); #1;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    n = 0;
    while (bus.S_AXI_RVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin timeout("rvalid_wait"); bus.S_AXI_RREADY = 1'b0; return; end
    data = bus.S_AXI_RDATA;
    check("rresp", 32'(bus.S_AXI_RRESP), 32'd0);
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic read_check(input string tag, input int addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(tag, d, exp);
    $display("[TB] read  %s addr=%03h data=%08h", tag, addr, d);
  endtask

  task automatic push_model();
    for (int n = 0; n < K*K; n++) axi_write(32'h100 + 4*n, m_k[n], 4'hF);
    for (int n = 0; n < W*W; n++) axi_write(32'h200 + 4*n, m_w[n], 4'hF);
  endtask

  task automatic wait_irq(input string tag);
    int n = 0;
    while (irq !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout(tag);
    @(posedge clk); #1;
  endtask

  task automatic start_op(input int i, input int j, output int start_at);
    axi_write(32'h008, 32'(i), 4'hF);
    axi_write(32'h00C, 32'(j), 4'hF);
    axi_write(32'h000, 32'h6, 4'hF);
    axi_write(32'h000, 32'h3, 4'hF);
    start_at = acc_cyc;
  endtask

  task automatic run_conv(input string tag, input int i, input int j, input logic [31:0] exp);
    int s_at;
    start_op(i, j, s_at);
    wait_irq({tag, "_done_wait"});
    check({tag, "_latency"}, 32'(rise_cyc - s_at), 32'd11);
    read_check({tag, "_result"}, 32'h010, exp);
    m_res = exp;
  endtask

  initial begin
    int s_at;
    int ii, jj;
    logic [31:0] d;
    int map_addr [7] = '{32'h000, 32'h004, 32'h008, 32'h00C, 32'h010, 32'h110, 32'h23C};

    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    for (int n = 0; n < K*K; n++) m_k[n] = '0;
    for (int n = 0; n < W*W; n++) m_w[n] = '0;
    m_res = '0;

    repeat (3) @(negedge clk);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_awready", 32'(bus.S_AXI_AWREADY), 32'd0);
    rst = 1'b0;

    // Everything mapped reads zero out of reset.
    for (int n = 0; n < 7; n++) read_check("reset_read", map_addr[n], 32'd0);
    check("reset_irq_after", 32'(irq), 32'd0);

    // Kernel 1..9, world all ones, centre (1,1).
    axi_write(32'h000, 32'h2, 4'hF);
    for (int n = 0; n < K*K; n++) m_k[n] = 32'(n + 1);
    for (int n = 0; n < W*W; n++) m_w[n] = 32'd1;
    push_model();
    run_conv("k19", 1, 1, 32'd45);
    check("k19_model", ref_conv(1, 1), 32'd45);
    check("k19_irq", 32'(irq), 32'd1);
    read_check("k19_status", 32'h004, 32'h2);

    // Corner cell: wrap vs zero-pad.
    for (int n = 0; n < K*K; n++) m_k[n] = 32'd1;
    for (int n = 0; n < W*W; n++) m_w[n] = 32'((n / W) * 4 + (n % W));
    push_model();
`ifdef CONV_WRAP_EN
    run_conv("corner", 0, 0, 32'd60);
`else
    run_conv("corner", 0, 0, 32'd10);
`endif

    // Signed product with a negative kernel tap.
    for (int n = 0; n < K*K; n++) m_k[n] = 32'd0;
    m_k[4] = 32'hFFFFFFFE;
    m_w[5] = 32'd7;
    push_model();
    run_conv("signed", 1, 1, 32'hFFFFFFF2);

    // Byte strobes, unmapped addresses, read-only RESULT.
    axi_write(32'h200, 32'hAABBCCDD, 4'hF);
    axi_write(32'h200, 32'h11223344, 4'b0101);
    m_w[0] = 32'hAA22CC44;
    read_check("wstrb", 32'h200, 32'hAA22CC44);
    axi_write(32'h050, 32'h12345678, 4'hF);
    read_check("unmapped", 32'h050, 32'd0);
    read_check("unmapped_hi", 32'h3FC, 32'd0);
    axi_write(32'h010, 32'h12345678, 4'hF);
    read_check("result_ro", 32'h010, m_res);

    // Writes and a second start while busy are discarded.
    for (int n = 0; n < K*K; n++) m_k[n] = $urandom;
    for (int n = 0; n < W*W; n++) m_w[n] = $urandom;
    push_model();
    start_op(2, 1, s_at);
    axi_write(32'h200 + 4*5, 32'h0000DEAD, 4'hF);
    axi_write(32'h000, 32'h3, 4'hF);
    wait_irq("busy_done_wait");
    check("busy_latency", 32'(rise_cyc - s_at), 32'd11);
    m_res = ref_conv(2, 1);
    read_check("busy_result", 32'h010, m_res);
    read_check("busy_world", 32'h200 + 4*5, m_w[5]);
    repeat (20) @(negedge clk);
    read_check("busy_single", 32'h004, 32'h2);

    // Out-of-range start flags err without touching RESULT.
    axi_write(32'h008, 32'd4, 4'hF);
    axi_write(32'h000, 32'h3, 4'hF);
    read_check("err_status", 32'h004, 32'h6);
    read_check("err_result", 32'h010, m_res);
    check("err_irq", 32'(irq), 32'd1);
    axi_write(32'h000, 32'h6, 4'hF);
    read_check("done_clr", 32'h004, 32'h4);

    // Randomized operands and centres, including edges.
    for (int t = 0; t < 6; t++) begin
      for (int n = 0; n < K*K; n++) m_k[n] = $urandom;
      for (int n = 0; n < W*W; n++) m_w[n] = $urandom;
      ii = int'($urandom_range(0, W - 1));
      jj = int'($urandom_range(0, W - 1));
      push_model();
      run_conv("random", ii, jj, ref_conv(ii, jj));
      $display("[TB] random run %0d i=%0d j=%0d result=%08h", t, ii, jj, m_res);
    end

    // Reset in the middle of MAC aborts everything.
    start_op(1, 2, s_at);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_bvalid", 32'(bus.S_AXI_BVALID), 32'd0);
    check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < K*K; n++) m_k[n] = '0;
    for (int n = 0; n < W*W; n++) m_w[n] = '0;
    read_check("rst_status", 32'h004, 32'd0);
    read_check("rst_result", 32'h010, 32'd0);
    read_check("rst_kernel", 32'h110, 32'd0);
    read_check("rst_ctrl", 32'h000, 32'd0);
    for (int n = 0; n < K*K; n++) m_k[n] = $urandom;
    for (int n = 0; n < W*W; n++) m_w[n] = $urandom;
    push_model();
    run_conv("post_rst", 1, 2, ref_conv(1, 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
